bin_to_bcd_seq: RTL and testbench



---
 rtl/bin_to_bcd_seq.sv | 126 ++++++++++++
 tb/tb_bin_to_bcd_seq.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-add-3), one iteration per clock.
// Optional macro LEADING_ZERO_BLANK_EN adds the registered blank_out port.
module bin_to_bcd_seq #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
`ifdef LEADING_ZERO_BLANK_EN
  output logic [DIGITS-1:0]     blank_out,
`endif
  output logic [4*DIGITS-1:0]   bcd_out
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic {S_IDLE, S_SHIFT} state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [WIDTH-1:0]      r_bin;
  logic [4*DIGITS-1:0]   r_work;
  logic [4*DIGITS-1:0]   r_bcd;
  logic [CW-1:0]         r_cnt;
  logic                  r_done;
  logic                  w_accept;
  logic                  w_last;
  logic [4*DIGITS-1:0]   w_adj;
  logic [4*DIGITS-1:0]   w_work_shift;

  // Each digit >= 5 gets +3 in isolation; no carry crosses nibble boundaries.
  function automatic logic [4*DIGITS-1:0] add3(input logic [4*DIGITS-1:0] w);
    logic [4*DIGITS-1:0] r;
    logic [3:0]          d;
    r = '0;
    for (int i = 0; i < DIGITS; i++) begin
      d = w[4*i +: 4];
      r[4*i +: 4] = (d >= 4'd5) ? d + 4'd3 : d;
    end
    return r;
  endfunction

`ifdef LEADING_ZERO_BLANK_EN
  // Bit i set when digit i and everything above it is zero; digit 0 always shown.
  function automatic logic [DIGITS-1:0] blank_of(input logic [4*DIGITS-1:0] w);
    logic [DIGITS-1:0] b;
    logic              z;
    z = 1'b1;
    b = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      z    = z & (w[4*i +: 4] == 4'd0);
      b[i] = z;
    end
    b[0] = 1'b0;
    return b;
  endfunction

  localparam logic [DIGITS-1:0] BLANK_RST = ~DIGITS'(1);
  logic [DIGITS-1:0] r_blank;
`endif

  assign w_accept     = (r_state == S_IDLE) && start;
  assign w_last       = (r_state == S_SHIFT) && (r_cnt == CW'(WIDTH - 1));
  assign w_adj        = add3(r_work);
  assign w_work_shift = (w_adj << 1) | {{(4*DIGITS-1){1'b0}}, r_bin[WIDTH-1]};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start)  w_state_nxt = S_SHIFT;
      S_SHIFT: if (w_last) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy    = (r_state == S_SHIFT);
    done    = r_done;
    bcd_out = r_bcd;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_bin  <= '0;
      r_work <= '0;
      r_cnt  <= '0;
      r_bcd  <= '0;
      r_done <= 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
      r_blank <= BLANK_RST;
`endif
    end else begin
      r_done <= w_last;
      if (w_accept) begin
        r_bin  <= bin_in;
        r_work <= '0;
        r_cnt  <= '0;
      end else if (r_state == S_SHIFT) begin
        r_work <= w_work_shift;
        r_bin  <= r_bin << 1;
        r_cnt  <= r_cnt + CW'(1);
      end
      // Result register only moves on the final iteration, so it holds between conversions.
      if (w_last) begin
        r_bcd <= w_work_shift;
`ifdef LEADING_ZERO_BLANK_EN
        r_blank <= blank_of(w_work_shift);
`endif
      end
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  assign blank_out = r_blank;
`endif

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench for bin_to_bcd_seq with a decimal-arithmetic reference model.
module tb_bin_to_bcd_seq;
  localparam int W = 16;
  localparam int D = 5;

  logic           clock = 1'b0;
  logic           reset;
  logic           start;
  logic [W-1:0]   bin_in;
  logic           busy;
  logic           done;
  logic [4*D-1:0] bcd_out;
`ifdef LEADING_ZERO_BLANK_EN
  logic [D-1:0]   blank_out;
`endif

  int n_checks = 0;
  int n_err    = 0;

  always #5 clock = ~clock;

  bin_to_bcd_seq #(.WIDTH(W), .DIGITS(D)) dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .bin_in   (bin_in),
    .busy     (busy),
    .done     (done),
`ifdef LEADING_ZERO_BLANK_EN
    .blank_out(blank_out),
`endif
    .bcd_out  (bcd_out)
  );

  function automatic logic [4*D-1:0] ref_bcd(input int unsigned v);
    logic [4*D-1:0] r;
    r = '0;
    for (int i = 0; i < D; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic logic [D-1:0] ref_blank(input int unsigned v);
    logic [D-1:0] b;
    int unsigned  p;
    p = 1;
    for (int i = 0; i < D; i++) begin
      b[i] = (i != 0) && (v < p);
      p = p * 10;
    end
    return b;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Waits for done, checking each busy cycle that busy is high and the old result is held.
  task automatic wait_done(input logic [4*D-1:0] hold_val, input bit drop_start,
                           input bit noise, input int poke, input logic [W-1:0] poke_val,
                           output int lat);
    lat = 0;
    while (lat < 40) begin
      @(negedge clock);
      lat++;
      if (lat == poke) begin
        start  = 1'b1;
        bin_in = poke_val;
      end else if (drop_start) begin
        start = 1'b0;
      end
      if (noise) bin_in = W'($urandom);
      if (done === 1'b1) break;
      chk("busy_hold", 64'({busy, done, bcd_out}), 64'({1'b1, 1'b0, hold_val}));
    end
  endtask

  task automatic check_result(input int unsigned v, input string tag);
    chk({tag, "_out"}, 64'({busy, done, bcd_out}), 64'({1'b0, 1'b1, ref_bcd(v)}));
`ifdef LEADING_ZERO_BLANK_EN
    chk({tag, "_blank"}, 64'(blank_out), 64'(ref_blank(v)));
`endif
  endtask

  task automatic conv(input int unsigned v, input logic [4*D-1:0] hold_val,
                      input bit noise, input string tag);
    int lat;
    start  = 1'b1;
    bin_in = W'(v);
    wait_done(hold_val, 1'b1, noise, -1, '0, lat);
    chk({tag, "_lat"}, 64'(lat), 64'(W + 1));
    check_result(v, tag);
  endtask

  initial begin
    int             lat;
    bit             seen;
    int unsigned    v;
    logic [4*D-1:0] prev;

    reset  = 1'b1;
    start  = 1'b0;
    bin_in = '0;
    #1;
    chk("reset_out", 64'({busy, done, bcd_out}), 64'(0));
`ifdef LEADING_ZERO_BLANK_EN
    chk("reset_blank", 64'(blank_out), 64'(~D'(1)));
`endif
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    conv(1234, '0, 1'b0, "t1");
    @(negedge clock);
    chk("t1_pulse", 64'({busy, done, bcd_out}), 64'({1'b0, 1'b0, ref_bcd(1234)}));

    conv(65535, ref_bcd(1234), 1'b0, "t2max");
    conv(0, ref_bcd(65535), 1'b0, "t2zero");
    @(negedge clock);

    // Start while busy must be ignored.
    start  = 1'b1;
    bin_in = W'(9999);
    wait_done(ref_bcd(0), 1'b1, 1'b0, 5, W'(42), lat);
    chk("t3_lat", 64'(lat), 64'(W + 1));
    check_result(9999, "t3");
    seen = 1'b0;
    repeat (20) begin
      @(negedge clock);
      if (busy !== 1'b0 || done !== 1'b0) seen = 1'b1;
    end
    chk("t3_no_second", 64'(seen), 64'(0));
    chk("t3_held", 64'(bcd_out), 64'(ref_bcd(9999)));

    // Back-to-back: start held through the done cycle.
    start  = 1'b1;
    bin_in = W'(500);
    wait_done(ref_bcd(9999), 1'b0, 1'b0, 1, W'(7), lat);
    chk("t4a_lat", 64'(lat), 64'(W + 1));
    check_result(500, "t4a");
    wait_done(ref_bcd(500), 1'b1, 1'b0, -1, '0, lat);
    chk("t4b_lat", 64'(lat), 64'(W + 1));
    check_result(7, "t4b");
    @(negedge clock);

    // Reset in the middle of a conversion.
    start  = 1'b1;
    bin_in = W'(4321);
    repeat (8) begin
      @(negedge clock);
      start = 1'b0;
    end
    chk("t5_busy_before", 64'(busy), 64'(1));
    reset = 1'b1;
    #1;
    chk("t5_reset_out", 64'({busy, done, bcd_out}), 64'(0));
    @(negedge clock);
    reset = 1'b0;
    seen  = 1'b0;
    repeat (25) begin
      @(negedge clock);
      if (done !== 1'b0 || busy !== 1'b0) seen = 1'b1;
    end
    chk("t5_no_done", 64'(seen), 64'(0));
    chk("t5_bcd_zero", 64'(bcd_out), 64'(0));
    conv(10, '0, 1'b0, "t5b");

    // Random back-to-back sweep with bin_in churning while busy.
    prev = ref_bcd(10);
    for (int k = 0; k < 200; k++) begin
      v = $urandom_range(0, 65535);
      conv(v, prev, 1'b1, "sweep");
      prev = ref_bcd(v);
    end
    start = 1'b0;
    @(negedge clock);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
